ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS-state cycles to wait for memFuncComplete.
REQ-002 The block SHALL have a single clock, Clk, and an asynchronous active-low reset, resetN; both are fixed and SHALL NOT be altered.
REQ-003 The ports SHALL be, in order:
- Clk  in  1  rising-edge clock
- resetN  in  1  asynchronous reset, active low
- iReq  in  1  fetch request, held until iAck
- iAddr  in  9  fetch byte address; the fetch is always a word read
- iAck  out  1  one-cycle fetch completion pulse
- iErr  out  1  valid with iAck; fetch failed
- iData  out  32  fetch data, valid with iAck
- dReq  in  1  data request, held until dAck
- dWrite  in  1  1 = write, 0 = read
- dAddr  in  9  data byte address
- dSize  in  2  00 byte, 01 halfword, 11 word
- dWData  in  32  write data, right-justified
- dAck  out  1  one-cycle data completion pulse
- dErr  out  1  valid with dAck; access failed
- dRData  out  32  read data, valid with dAck
- memFuncActive  out  1  RAM strobe
- readWrite  out  1  RAM direction, 1 = write
- address  out  9  RAM address
- ramDataIn  out  32  RAM write data
- dataSize  out  2  RAM size code
- ramDataOut  in  32  RAM read data
- memFuncComplete  in  1  RAM completion flag

Function
REQ-004 The controller SHALL be an FSM with the states IDLE, ACCESS and RESP.
REQ-005 In IDLE, when at least one request is valid, the next edge SHALL grant one requester, register address, readWrite, dataSize and ramDataIn, assert memFuncActive, and move to ACCESS.
REQ-006 Arbitration SHALL be two-way round-robin.
- A sole requester wins.
- On a tie, the requester not granted last wins.
- The fetch requester SHALL be driven as readWrite=0, dataSize=11.
REQ-007 In ACCESS, an edge that samples memFuncComplete=1 SHALL do all of the following:
- latch ramDataOut into iData or dRData (reads) or leave it unchanged (writes);
- deassert memFuncActive;
- assert the granted ack for exactly one cycle with err=0;
- move to RESP.
REQ-008 RESP SHALL return to IDLE on the next edge, so memFuncActive stays low for at least 2 cycles between accesses and every access presents a fresh rising strobe.
REQ-009 Minimum latency SHALL be 3 edges from the first edge sampling the request to ack high; sustained throughput SHALL be one access per 4 cycles.
REQ-010 A cycle counter SHALL run in ACCESS. If it reaches TIMEOUT without memFuncComplete, the access SHALL terminate as in REQ-007, with err=1 and the response data forced to 0.
REQ-011 A data request with dSize=10 SHALL NOT access the RAM. It SHALL be granted normally, go directly to RESP, and produce dAck=1, dErr=1 and dRData=0 one edge after the grant.
REQ-012 Address/size outputs SHALL be held constant from grant until RESP. A request deasserted before grant SHALL be ignored. A requester changing its attributes before ack causes undefined results.
REQ-013 With the alignment check compiled out, address wrap-around (e.g. word at 510) SHALL be passed unchanged to the RAM.
REQ-014 At most one of iAck and dAck SHALL be high in any cycle.

Reset
REQ-015 While resetN=0, the block SHALL immediately force:
- state = IDLE;
- memFuncActive, readWrite, iAck, dAck, iErr, dErr = 0;
- address = 0, dataSize = 00, ramDataIn = 0;
- iData and dRData = 0;
- the timeout counter to 0;
- the last-granted marker to fetch, so data wins the first tie.
REQ-016 Reset asserted during ACCESS SHALL abandon the access with no ack. After release, the FSM SHALL resume from IDLE.

Configuration
REQ-017 When RAM_ARB_ALIGN_CHECK_EN is defined, misaligned data requests SHALL be rejected as in REQ-011, with no RAM access.
- word: dAddr[1:0] != 00 is misaligned;
- halfword: dAddr[0] != 0 is misaligned;
- fetch: iAddr[1:0] != 00 is misaligned.
REQ-018 When RAM_ARB_ALIGN_CHECK_EN is undefined, no alignment check SHALL exist and all addresses SHALL pass through.

Structure
REQ-019 Package ram_arb_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum and the TIMEOUT default.
REQ-020 The round-robin picker SHALL be a sub-module, ram_arb_rr, with inputs iReq, dReq and lastGrant, and a grant output.

Verification
REQ-021 Fetch read: iReq at address 0, with the RAM returning 0x00000821 -> memFuncActive rises, iAck pulses 3 edges after the request is sampled, iData = 0x00000821, iErr = 0.
REQ-022 Tie: iReq and dReq asserted together from reset -> data is served first, then fetch. Both remain asserted for 4 grants -> the grant order is D, I, D, I.
REQ-023 Halfword write: dAddr = 40, dSize = 01, dWData = 0x0000BEEF -> address = 40, readWrite = 1, ramDataIn = 0x0000BEEF, and dAck pulses with dErr = 0.
REQ-024 Timeout: memFuncComplete held at 0 -> dAck with dErr = 1 and dRData = 0 after TIMEOUT cycles, then the FSM returns to IDLE.
REQ-025 Errors: dSize = 10 -> dErr = 1 with no memFuncActive pulse. With RAM_ARB_ALIGN_CHECK_EN defined, a word access at dAddr = 2 -> dErr = 1; undefined, the same access is passed through to the RAM.
REQ-026 Reset mid-access: resetN pulsed low in ACCESS -> all outputs are 0 at once and no ack is produced. A new request after reset is served normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for ram_arbiter: size codes, FSM states, grant encoding
// and the default ACCESS-state timeout.
package ram_arb_pkg;

  localparam int TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // True when an access of the given size cannot start at the given low address bits.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_WORD && addr_lo != 2'b00) bad = 1'b1;
    if (size == SZ_HALF && addr_lo[0]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the
// requester that was not granted last. Output is only meaningful when a request is up.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic iReq,
  input  logic dReq,
  input  gnt_e lastGrant,
  output gnt_e grant
);

  always_comb begin
    grant = GNT_D;
    if (iReq && !dReq) begin
      grant = GNT_I;
    end else if (iReq && dReq && lastGrant == GNT_D) begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: fetch/data round-robin front end for a single-port RAM.
// Define RAM_ARB_ALIGN_CHECK_EN to reject misaligned requests without a RAM access.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        resetN,
  input  logic        iReq,
  input  logic [8:0]  iAddr,
  output logic        iAck,
  output logic        iErr,
  output logic [31:0] iData,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [8:0]  dAddr,
  input  logic [1:0]  dSize,
  input  logic [31:0] dWData,
  output logic        dAck,
  output logic        dErr,
  output logic [31:0] dRData,
  output logic        memFuncActive,
  output logic        readWrite,
  output logic [8:0]  address,
  output logic [31:0] ramDataIn,
  output logic [1:0]  dataSize,
  input  logic [31:0] ramDataOut,
  input  logic        memFuncComplete
);

  // Handshake: a requester raises req with stable attributes and holds it until
  // its ack; ack is a registered one-cycle pulse with err and data valid alongside.
  // A request dropped before the IDLE edge that would grant it is never seen.

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state, state_n;
  gnt_e             gnt, gnt_n;
  gnt_e             last_grant, last_n;
  gnt_e             rr_grant;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic        act_n, rw_n;
  logic [8:0]  addr_n;
  logic [1:0]  size_n;
  logic [31:0] wdata_n;
  logic        iack_n, ierr_n, dack_n, derr_n;
  logic [31:0] idata_n, drdata_n;
  logic        d_bad, i_bad;
  logic        done, timed_out;

  ram_arb_rr u_rr (
    .iReq      (iReq),
    .dReq      (dReq),
    .lastGrant (last_grant),
    .grant     (rr_grant)
  );

`ifdef RAM_ARB_ALIGN_CHECK_EN
  assign d_bad = (dSize == SZ_RSVD) || size_misaligned(dSize, dAddr[1:0]);
  assign i_bad = size_misaligned(SZ_WORD, iAddr[1:0]);
`else
  assign d_bad = (dSize == SZ_RSVD);
  assign i_bad = 1'b0;
`endif

  assign done      = memFuncComplete || (cnt == CNT_LAST);
  assign timed_out = !memFuncComplete;

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_n   = last_grant;
    cnt_n    = cnt;
    act_n    = memFuncActive;
    rw_n     = readWrite;
    addr_n   = address;
    size_n   = dataSize;
    wdata_n  = ramDataIn;
    iack_n   = 1'b0;
    ierr_n   = 1'b0;
    dack_n   = 1'b0;
    derr_n   = 1'b0;
    idata_n  = iData;
    drdata_n = dRData;

    case (state)
      IDLE: begin
        if (iReq || dReq) begin
          gnt_n  = rr_grant;
          last_n = rr_grant;
          cnt_n  = '0;
          if (rr_grant == GNT_D && d_bad) begin
            // Rejected requests skip the RAM entirely and answer on the grant edge.
            state_n  = RESP;
            dack_n   = 1'b1;
            derr_n   = 1'b1;
            drdata_n = '0;
          end else if (rr_grant == GNT_I && i_bad) begin
            state_n = RESP;
            iack_n  = 1'b1;
            ierr_n  = 1'b1;
            idata_n = '0;
          end else begin
            state_n = ACCESS;
            act_n   = 1'b1;
            if (rr_grant == GNT_I) begin
              addr_n  = iAddr;
              rw_n    = 1'b0;
              size_n  = SZ_WORD;
              wdata_n = '0;
            end else begin
              addr_n  = dAddr;
              rw_n    = dWrite;
              size_n  = dSize;
              wdata_n = dWData;
            end
          end
        end
      end

      ACCESS: begin
        if (done) begin
          state_n = RESP;
          act_n   = 1'b0;
          if (gnt == GNT_I) begin
            iack_n  = 1'b1;
            ierr_n  = timed_out;
            idata_n = timed_out ? '0 : ramDataOut;
          end else begin
            dack_n = 1'b1;
            derr_n = timed_out;
            if (timed_out) begin
              drdata_n = '0;
            end else if (!readWrite) begin
              drdata_n = ramDataOut;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        // One dead cycle guarantees a fresh rising strobe for the next access.
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        act_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge resetN) begin
    if (!resetN) begin
      state         <= IDLE;
      gnt           <= GNT_I;
      last_grant    <= GNT_I;
      cnt           <= '0;
      memFuncActive <= 1'b0;
      readWrite     <= 1'b0;
      address       <= '0;
      dataSize      <= SZ_BYTE;
      ramDataIn     <= '0;
      iAck          <= 1'b0;
      iErr          <= 1'b0;
      iData         <= '0;
      dAck          <= 1'b0;
      dErr          <= 1'b0;
      dRData        <= '0;
    end else begin
      state         <= state_n;
      gnt           <= gnt_n;
      last_grant    <= last_n;
      cnt           <= cnt_n;
      memFuncActive <= act_n;
      readWrite     <= rw_n;
      address       <= addr_n;
      dataSize      <= size_n;
      ramDataIn     <= wdata_n;
      iAck          <= iack_n;
      iErr          <= ierr_n;
      iData         <= idata_n;
      dAck          <= dack_n;
      dErr          <= derr_n;
      dRData        <= drdata_n;
    end
  end

endmodule
